// File: rtl/ftdi_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// ftdi_tx_arbiter_if
//   Bundles the channel-side stream handshake and the FTDI 245-sync-FIFO
//   write-side pad signals used by ftdi_tx_arbiter.
//   master : the arbiter (consumes ch_*, drives ftdi_* outputs and ch_ready)
//   slave  : the environment (channel FIFOs + pads / chip model)
// Signals
//   ch_data[N_CH*DATA_W]  channel c word at [c*DATA_W +: DATA_W]
//   ch_valid[N_CH]        channel word available
//   ch_ready[N_CH]        word taken when valid & ready on the same edge
//   ftdi_txe_n            low = chip can accept a write
//   ftdi_data_out         word driven to the DATA pads
//   ftdi_data_oe          DATA pad output enable
//   ftdi_be               byte enables to the BE pads
//   ftdi_wr_n / rd_n / oe_n  chip strobes, active low
// ---------------------------------------------------------------------------
interface ftdi_tx_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 4
);
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_valid;
  logic [N_CH-1:0]        ch_ready;
  logic                   ftdi_txe_n;
  logic [DATA_W-1:0]      ftdi_data_out;
  logic                   ftdi_data_oe;
  logic [DATA_W/8-1:0]    ftdi_be;
  logic                   ftdi_wr_n;
  logic                   ftdi_rd_n;
  logic                   ftdi_oe_n;

  modport master (
    input  ch_data, ch_valid, ftdi_txe_n,
    output ch_ready, ftdi_data_out, ftdi_data_oe, ftdi_be,
           ftdi_wr_n, ftdi_rd_n, ftdi_oe_n
  );

  modport slave (
    output ch_data, ch_valid, ftdi_txe_n,
    input  ch_ready, ftdi_data_out, ftdi_data_oe, ftdi_be,
           ftdi_wr_n, ftdi_rd_n, ftdi_oe_n
  );
endinterface

// File: rtl/ftdi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ftdi_tx_arbiter
//   N-channel stream to FTDI 245-sync-FIFO write master (FT600 16 bit /
//   FT601 32 bit). Round-robin grants one channel at a time and moves up to
//   BURST_LEN words from it through a single output register onto the bus.
//   All logic runs on the FTDI bus clock.
// Ports
//   clk     FTDI bus clock, rising edge
//   rst     asynchronous, active-high reset
//   bus     ftdi_tx_arbiter_if.master (channel streams + FTDI write pads)
//   busy    FSM not in IDLE
//   cur_ch  current / last granted channel
// Configuration
//   FTX_HEADER_EN  when defined, each grant is prefixed with one header word
//                  {A5, ch, seq} (32 bit) / {A, ch, seq} (16 bit), with a
//                  wrapping per-channel sequence counter.
// ---------------------------------------------------------------------------
module ftdi_tx_arbiter #(
  parameter int  DATA_W    = 32,
  parameter int  N_CH      = 4,
  parameter int  BURST_LEN = 64,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ftdi_tx_arbiter_if.master     bus,
  output logic                  busy,
  output logic [CH_W-1:0]       cur_ch
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef FTX_HEADER_EN
    S_HDR   = 2'd1,
`endif
    S_BURST = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  // Set after the first grant so that the very first search starts at ch0.
  logic              granted_q, granted_d;

  logic              accept, slot, room;
  logic [N_CH-1:0]   ready_vec;
  logic              any_valid;
  logic [CH_W-1:0]   next_ch;
  int                base, idx;

  assign accept = ov_q & ~bus.ftdi_txe_n;
  assign slot   = ~ov_q | accept;
  assign room   = slot & (cnt_q < CNT_W'(BURST_LEN));

  // Round-robin search: first valid channel strictly after the last grant.
  always_comb begin
    any_valid = 1'b0;
    next_ch   = '0;
    idx       = 0;
    base      = granted_q ? int'(cur_ch_q) + 1 : 0;
    if (base >= N_CH) base = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = base + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!any_valid && bus.ch_valid[idx]) begin
        any_valid = 1'b1;
        next_ch   = CH_W'(idx);
      end
    end
  end

`ifdef FTX_HEADER_EN
  localparam int SEQ_W = DATA_W / 2;
  logic [SEQ_W-1:0]  seq_q [N_CH];
  logic              seq_inc;
  logic [DATA_W-1:0] hdr_word;

  always_comb begin
    if (DATA_W == 32) hdr_word = DATA_W'({8'hA5, 8'(cur_ch_q), 16'(seq_q[cur_ch_q])});
    else              hdr_word = DATA_W'({4'hA, 4'(cur_ch_q), 8'(seq_q[cur_ch_q])});
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is
  // cleared by reset like any other state; real memories would not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) seq_q[c] <= '0;
    end else if (seq_inc) begin
      seq_q[cur_ch_q] <= seq_q[cur_ch_q] + 1'b1;
    end
  end
`endif

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    ov_d      = ov_q & ~accept;   // a written word leaves unless replaced
    word_d    = word_q;
    cnt_d     = cnt_q;
    cur_ch_d  = cur_ch_q;
    granted_d = granted_q;
    ready_vec = '0;
`ifdef FTX_HEADER_EN
    seq_inc   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          cur_ch_d  = next_ch;
          granted_d = 1'b1;
          cnt_d     = '0;
`ifdef FTX_HEADER_EN
          state_d   = S_HDR;
`else
          state_d   = S_BURST;
`endif
        end
      end
`ifdef FTX_HEADER_EN
      S_HDR: begin
        if (slot) begin
          ov_d    = 1'b1;
          word_d  = hdr_word;
          seq_inc = 1'b1;
          state_d = S_BURST;
        end
      end
`endif
      S_BURST: begin
        if (room) ready_vec[cur_ch_q] = 1'b1;
        if (room && bus.ch_valid[cur_ch_q]) begin
          ov_d   = 1'b1;
          word_d = bus.ch_data[int'(cur_ch_q)*DATA_W +: DATA_W];
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == CNT_W'(BURST_LEN)) state_d = S_DRAIN;
        end else if (slot) begin
          // Channel ran dry (or burst full): never stall the bus waiting.
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!ov_q || accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ov_q      <= 1'b0;
      word_q    <= '0;
      cnt_q     <= '0;
      cur_ch_q  <= '0;
      granted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ov_q      <= ov_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      cur_ch_q  <= cur_ch_d;
      granted_q <= granted_d;
    end
  end

  // Pad-facing signals come straight from the output register flops.
  assign bus.ch_ready      = ready_vec;
  assign bus.ftdi_wr_n     = ~ov_q;
  assign bus.ftdi_data_oe  = ov_q;
  assign bus.ftdi_be       = {BE_W{ov_q}};
  assign bus.ftdi_data_out = word_q;
  assign bus.ftdi_rd_n     = 1'b1;
  assign bus.ftdi_oe_n     = 1'b1;
  assign busy              = (state_q != S_IDLE);
  assign cur_ch            = cur_ch_q;

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ftdi_tx_arbiter
//   Randomized bench for ftdi_tx_arbiter (DATA_W=32, N_CH=4, BURST_LEN=4).
//   Channel sources emit {ch, index} words; a transaction-level model checks
//   the bus stream: per-channel order without loss/duplication, one channel
//   per burst, burst size limit, inter-burst gap, round-robin order under
//   saturation, load latency, stall hold and reset behaviour.
// ---------------------------------------------------------------------------
module tb_ftdi_tx_arbiter;
  localparam int DATA_W    = 32;
  localparam int N_CH      = 4;
  localparam int BURST_LEN = 4;
  localparam int CH_W      = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            busy;
  logic [CH_W-1:0] cur_ch;

  ftdi_tx_arbiter_if #(.DATA_W(DATA_W), .N_CH(N_CH)) bus ();

  ftdi_tx_arbiter #(.DATA_W(DATA_W), .N_CH(N_CH), .BURST_LEN(BURST_LEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .cur_ch (cur_ch)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- source model ----------------
  int quota [N_CH];
  int taken [N_CH];
  int sent  [N_CH];
  int seq_m [N_CH];
  int valid_pct, txe_hi_pct;
  logic [N_CH-1:0] fire_pend;

  function automatic logic [31:0] word_of(input int c, input int i);
    return {4'(c), 28'(i)};
  endfunction

  // ---------------- bus monitor model ----------------
  bit   in_run, any_run, full_mode;
  int   run_ch, run_len, pos, gap, exp_ch;
  int   run_lens[$];
  logic prev_wr_n, prev_txe;
  logic [31:0] prev_data;
  bit   had_fire;
  logic [31:0] fired_word;

  task automatic start_burst(input int ch);
    check("cur_ch", 32'(cur_ch), 32'(ch));
    if (full_mode) begin
      check("rr_order", 32'(ch), 32'(exp_ch));
      exp_ch = (exp_ch + 1) % N_CH;
    end
    run_ch = ch;
  endtask

  task automatic monitor();
    logic        wr_n, acc, is_hdr;
    logic [31:0] d;
    int          ch;
    wr_n = bus.ftdi_wr_n;
    d    = bus.ftdi_data_out;
    acc  = !wr_n && !bus.ftdi_txe_n;
    if (had_fire) begin
      check("load_wr_n", 32'(wr_n), 0);
      check("load_data", d, fired_word);
    end
    if (!prev_wr_n && prev_txe) begin
      check("hold_wr_n", 32'(wr_n), 0);
      check("hold_data", d, prev_data);
    end
    if (!wr_n && bus.ftdi_txe_n) check("stall_ready", 32'(bus.ch_ready), 0);
    check("data_oe", 32'(bus.ftdi_data_oe), 32'(!wr_n));
    check("be", 32'(bus.ftdi_be), wr_n ? 32'h0 : 32'hF);
    if (!wr_n) check("busy", 32'(busy), 1);
    if (!wr_n) begin
      if (!in_run) begin
        if (any_run) check("burst_gap", 32'(gap >= 2), 1);
        in_run = 1; any_run = 1; run_len = 0; pos = 0; run_ch = -1;
      end
      if (acc) begin
        is_hdr = 1'b0;
`ifdef FTX_HEADER_EN
        is_hdr = (pos == 0);
`endif
        if (is_hdr) begin
          ch = int'(d[23:16]);
          if (ch >= N_CH) begin check("hdr_ch_range", 32'(ch), 0); ch = 0; end
          check("hdr_tag", 32'(d[31:24]), 32'hA5);
          check("hdr_seq", 32'(d[15:0]), 32'(seq_m[ch] & 16'hFFFF));
          seq_m[ch]++;
          start_burst(ch);
        end else begin
          ch = int'(d[31:28]);
          if (ch >= N_CH) begin check("pay_ch_range", 32'(ch), 0); ch = 0; end
          if (pos == 0) start_burst(ch);
          check("burst_ch", 32'(ch), 32'(run_ch));
          check("payload", d, word_of(ch, sent[ch]));
          sent[ch]++;
          run_len++;
          check("burst_max", 32'(run_len <= BURST_LEN), 1);
        end
        pos++;
      end
    end else begin
      if (in_run) begin
        in_run = 0;
        if (full_mode) check("burst_len", 32'(run_len), BURST_LEN);
        run_lens.push_back(run_len);
        gap = 0;
      end
      gap++;
    end
    prev_wr_n = wr_n;
    prev_txe  = bus.ftdi_txe_n;
    prev_data = d;
  endtask

  // One bus cycle: account for last edge's transfers, drive, then observe.
  task automatic step();
    @(negedge clk);
    had_fire = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (fire_pend[c]) begin
        had_fire   = 1'b1;
        fired_word = word_of(c, taken[c]);
        taken[c]++;
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      bus.ch_valid[c] = (taken[c] < quota[c]) && ($urandom_range(99) < valid_pct);
      bus.ch_data[c*DATA_W +: DATA_W] = word_of(c, taken[c]);
    end
    bus.ftdi_txe_n = ($urandom_range(99) < txe_hi_pct);
    #1;
    monitor();
    fire_pend = bus.ch_valid & bus.ch_ready;
  endtask

  task automatic run_phase(input string name, input int budget);
    bit done;
    done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      step();
      done = !in_run;
      for (int c = 0; c < N_CH; c++) if (sent[c] != quota[c]) done = 0;
    end
    check({name, "_timeout"}, 32'(done), 1);
    for (int c = 0; c < N_CH; c++) check({name, "_count"}, 32'(sent[c]), 32'(quota[c]));
  endtask

  initial begin
    rst = 1'b1;
    bus.ch_valid = '0; bus.ch_data = '0; bus.ftdi_txe_n = 1'b1;
    for (int c = 0; c < N_CH; c++) begin quota[c] = 0; taken[c] = 0; sent[c] = 0; seq_m[c] = 0; end
    valid_pct = 0; txe_hi_pct = 100; fire_pend = '0;
    in_run = 0; any_run = 0; full_mode = 0; gap = 0; exp_ch = 0; pos = 0; run_len = 0; run_ch = -1;
    prev_wr_n = 1'b1; prev_txe = 1'b1; prev_data = '0; had_fire = 0; fired_word = '0;

    // Reset state
    #12;
    check("rst_wr_n", 32'(bus.ftdi_wr_n), 1);
    check("rst_rd_n", 32'(bus.ftdi_rd_n), 1);
    check("rst_oe_n", 32'(bus.ftdi_oe_n), 1);
    check("rst_data", bus.ftdi_data_out, 0);
    check("rst_be", 32'(bus.ftdi_be), 0);
    check("rst_data_oe", 32'(bus.ftdi_data_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cur_ch", 32'(cur_ch), 0);
    check("rst_ready", 32'(bus.ch_ready), 0);
    @(negedge clk); rst = 1'b0;

    // Saturated: every channel always valid, 3 full bursts each, random txe.
    full_mode = 1; valid_pct = 100; txe_hi_pct = 25;
    for (int c = 0; c < N_CH; c++) quota[c] = 3 * BURST_LEN;
    run_phase("sat", 2000);
    check("sat_bursts", 32'(run_lens.size()), 3 * N_CH);
    full_mode = 0;

    // Random valid gaps and random quotas.
    for (int r = 0; r < 3; r++) begin
      valid_pct = 70; txe_hi_pct = 30;
      for (int c = 0; c < N_CH; c++) quota[c] = taken[c] + $urandom_range(0, 20);
      run_phase("rand", 4000);
    end

    // Single channel, 10 words, chip always ready: bursts of 4,4,2.
    repeat (4) step();
    run_lens.delete();
    valid_pct = 100; txe_hi_pct = 0;
    quota[0] = taken[0] + 10;
    run_phase("single", 500);
    check("single_nbursts", 32'(run_lens.size()), 3);
    if (run_lens.size() == 3) begin
      check("single_len0", 32'(run_lens[0]), 4);
      check("single_len1", 32'(run_lens[1]), 4);
      check("single_len2", 32'(run_lens[2]), 2);
    end

    // Reset mid-burst while a word is held on the bus.
    valid_pct = 100; txe_hi_pct = 100;
    quota[1] = taken[1] + 50;
    begin
      bit seen;
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
        step();
        seen = !bus.ftdi_wr_n;
      end
      check("midrst_wr_low_seen", 32'(seen), 1);
    end
    #1 rst = 1'b1;
    #1;
    check("midrst_wr_n", 32'(bus.ftdi_wr_n), 1);
    check("midrst_be", 32'(bus.ftdi_be), 0);
    check("midrst_data_oe", 32'(bus.ftdi_data_oe), 0);
    check("midrst_ready", 32'(bus.ch_ready), 0);
    check("midrst_busy", 32'(busy), 0);
    @(negedge clk); rst = 1'b0;
    bus.ch_valid = '0; bus.ftdi_txe_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("postrst_wr_n", 32'(bus.ftdi_wr_n), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
